// File: rtl/xm_result_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | xm_result_stage                                                           |
// | Execute-to-memory result buffer: overflow exceptions, branch redirects.   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module xm_result_stage #(
  parameter int CNT_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_opcode,
  input  logic [4:0]        in_aluop,
  input  logic [4:0]        in_rd,
  input  logic [31:0]       in_alu_result,
  input  logic              in_ne,
  input  logic              in_lt,
  input  logic              in_ovf,
  input  logic [31:0]       in_store_data,
  input  logic [31:0]       in_branch_target,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result,
  output logic [4:0]        out_rd,
  output logic              out_we,
  output logic              out_mem_we,
  output logic              out_mem_re,
  output logic [31:0]       out_store_data,
  output logic              redirect,
  output logic [31:0]       redirect_pc,
  output logic [CNT_W-1:0]  ovf_count
);

  localparam logic [4:0] c_op_rtype  = 5'b00000;
  localparam logic [4:0] c_op_addi   = 5'b00101;
  localparam logic [4:0] c_op_bne    = 5'b00010;
  localparam logic [4:0] c_op_blt    = 5'b00110;
  localparam logic [4:0] c_op_sw     = 5'b00111;
  localparam logic [4:0] c_op_lw     = 5'b01000;
  localparam logic [4:0] c_alu_add   = 5'b00000;
  localparam logic [4:0] c_alu_sub   = 5'b00001;
  localparam logic [4:0] c_rd_status = 5'd30;
  localparam logic [CNT_W-1:0] c_cnt_max = '1;
  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  logic        w_capture;
  logic        w_is_rtype;
  logic        w_exc;
  logic        w_taken;
  logic        w_we;
  logic [1:0]  w_code;
  logic [31:0] w_result;
  logic [4:0]  w_rd;

  assign in_ready  = !out_valid || out_ready;
  assign w_capture = in_valid && in_ready && !flush;

  always_comb begin
    w_is_rtype = (in_opcode == c_op_rtype);
    w_code     = 2'd0;
    w_exc      = 1'b0;
    // Only add/addi/sub can raise; ovf from other ALU ops is meaningless here
    if (in_ovf) begin
      if (in_opcode == c_op_addi) begin
        w_exc  = 1'b1;
        w_code = 2'd2;
      end else if (w_is_rtype && in_aluop == c_alu_add) begin
        w_exc  = 1'b1;
        w_code = 2'd1;
      end else if (w_is_rtype && in_aluop == c_alu_sub) begin
        w_exc  = 1'b1;
        w_code = 2'd3;
      end
    end
    w_result = w_exc ? {30'd0, w_code} : in_alu_result;
    w_rd     = w_exc ? c_rd_status : in_rd;
    w_we     = w_exc ||
               ((w_is_rtype || in_opcode == c_op_addi || in_opcode == c_op_lw) &&
                (in_rd != 5'd0));
    w_taken  = (in_opcode == c_op_bne && in_ne) || (in_opcode == c_op_blt && in_lt);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid      <= 1'b0;
      out_result     <= 32'd0;
      out_rd         <= 5'd0;
      out_we         <= 1'b0;
      out_mem_we     <= 1'b0;
      out_mem_re     <= 1'b0;
      out_store_data <= 32'd0;
      redirect       <= 1'b0;
      redirect_pc    <= 32'd0;
      ovf_count      <= '0;
    end else begin
      redirect <= w_capture && w_taken;
      if (w_capture && w_taken) begin
        redirect_pc <= in_branch_target;
      end
      if (flush) begin
        out_valid <= 1'b0;
      end else if (w_capture) begin
        out_valid      <= 1'b1;
        out_result     <= w_result;
        out_rd         <= w_rd;
        out_we         <= w_we;
        out_mem_we     <= (in_opcode == c_op_sw);
        out_mem_re     <= (in_opcode == c_op_lw);
        out_store_data <= in_store_data;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (w_capture && w_exc && ovf_count != c_cnt_max) begin
        ovf_count <= ovf_count + c_cnt_one;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_xm_result_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_xm_result_stage                                                        |
// | Scoreboard bench for the execute-to-memory result stage.                  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_xm_result_stage;

  localparam int CNT_W = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [4:0]        in_opcode = '0;
  logic [4:0]        in_aluop = '0;
  logic [4:0]        in_rd = '0;
  logic [31:0]       in_alu_result = '0;
  logic              in_ne = 1'b0;
  logic              in_lt = 1'b0;
  logic              in_ovf = 1'b0;
  logic [31:0]       in_store_data = '0;
  logic [31:0]       in_branch_target = '0;
  logic              flush = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [31:0]       out_result;
  logic [4:0]        out_rd;
  logic              out_we;
  logic              out_mem_we;
  logic              out_mem_re;
  logic [31:0]       out_store_data;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic [CNT_W-1:0]  ovf_count;

  xm_result_stage #(.CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_aluop(in_aluop), .in_rd(in_rd),
    .in_alu_result(in_alu_result), .in_ne(in_ne), .in_lt(in_lt), .in_ovf(in_ovf),
    .in_store_data(in_store_data), .in_branch_target(in_branch_target),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_we(out_we),
    .out_mem_we(out_mem_we), .out_mem_re(out_mem_re), .out_store_data(out_store_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .ovf_count(ovf_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        we;
    logic        mwe;
    logic        mre;
    logic [31:0] sd;
  } exp_t;

  exp_t             r_q[$];
  int               n_cmp = 0;
  int               n_err = 0;
  logic             r_e_red = 1'b0;
  logic [31:0]      r_e_pc = '0;
  logic [CNT_W-1:0] r_e_cnt = '0;
  logic             r_last_acc = 1'b0;
  logic             w_acc;
  exp_t             r_head;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic is_exc(input logic [4:0] op, input logic [4:0] alu, input logic ovf);
    return ovf && (op == 5'b00101 || (op == 5'b00000 && (alu == 5'd0 || alu == 5'd1)));
  endfunction

  function automatic exp_t model(input logic [4:0] op, input logic [4:0] alu, input logic [4:0] rd,
                                 input logic [31:0] res, input logic ovf, input logic [31:0] sd);
    exp_t e;
    logic exc;
    logic [31:0] code;
    exc  = is_exc(op, alu, ovf);
    code = (op == 5'b00101) ? 32'd2 : ((alu == 5'd1) ? 32'd3 : 32'd1);
    e.result = exc ? code : res;
    e.rd     = exc ? 5'd30 : rd;
    e.we     = exc || ((op == 5'b00000 || op == 5'b00101 || op == 5'b01000) && rd != 5'd0);
    e.mwe    = (op == 5'b00111);
    e.mre    = (op == 5'b01000);
    e.sd     = sd;
    return e;
  endfunction

  // Monitor/scoreboard: checks on the falling edge, then predicts the next rising edge
  always @(negedge clock) begin
    if (!reset) begin
      r_q.delete();
      r_e_red    = 1'b0;
      r_e_pc     = '0;
      r_e_cnt    = '0;
      r_last_acc = 1'b0;
    end else begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, r_q.size() != 0});
      chk("in_ready", {31'd0, in_ready}, {31'd0, (r_q.size() == 0) || out_ready});
      chk("redirect", {31'd0, redirect}, {31'd0, r_e_red});
      if (r_e_red) chk("redirect_pc", redirect_pc, r_e_pc);
      chk("ovf_count", {28'd0, ovf_count}, {28'd0, r_e_cnt});
      if (r_q.size() != 0) begin
        r_head = r_q[0];
        chk("out_result", out_result, r_head.result);
        chk("out_rd", {27'd0, out_rd}, {27'd0, r_head.rd});
        chk("out_we", {31'd0, out_we}, {31'd0, r_head.we});
        chk("out_mem_we", {31'd0, out_mem_we}, {31'd0, r_head.mwe});
        chk("out_mem_re", {31'd0, out_mem_re}, {31'd0, r_head.mre});
        chk("out_store_data", out_store_data, r_head.sd);
      end
      w_acc = in_valid && (r_q.size() == 0 || out_ready) && !flush;
      if (r_q.size() != 0 && (flush || out_ready)) void'(r_q.pop_front());
      if (w_acc) begin
        r_q.push_back(model(in_opcode, in_aluop, in_rd, in_alu_result, in_ovf, in_store_data));
        if (is_exc(in_opcode, in_aluop, in_ovf) && r_e_cnt != '1) r_e_cnt = r_e_cnt + 1'b1;
      end
      r_e_red = w_acc && ((in_opcode == 5'b00010 && in_ne) || (in_opcode == 5'b00110 && in_lt));
      if (r_e_red) r_e_pc = in_branch_target;
      r_last_acc = w_acc;
    end
  end

  task automatic offer(input logic [4:0] op, input logic [4:0] alu, input logic [4:0] rd,
                       input logic [31:0] res, input logic ne, input logic lt, input logic ovf,
                       input logic [31:0] sd, input logic [31:0] tgt);
    in_opcode = op; in_aluop = alu; in_rd = rd; in_alu_result = res;
    in_ne = ne; in_lt = lt; in_ovf = ovf; in_store_data = sd; in_branch_target = tgt;
    in_valid = 1'b1;
  endtask

  task automatic wait_acc();
    int n = 0;
    do begin
      @(posedge clock);
      n++;
    end while (!r_last_acc && n < 50);
    chk("accept", {31'd0, r_last_acc}, 32'd1);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [4:0] op, input logic [4:0] alu, input logic [4:0] rd,
                      input logic [31:0] res, input logic ne, input logic lt, input logic ovf,
                      input logic [31:0] sd, input logic [31:0] tgt);
    offer(op, alu, rd, res, ne, lt, ovf, sd, tgt);
    wait_acc();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_ovf_count", {28'd0, ovf_count}, 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    reset = 1'b1;
    idle(1);

    send(5'b00000, 5'd0, 5'd3, 32'd12, 0, 0, 0, 32'h0, 32'h0);
    chk("add_result", out_result, 32'd12);
    send(5'b00101, 5'd0, 5'd4, 32'hDEAD, 0, 0, 1, 32'h0, 32'h0);
    chk("addi_exc_rd", {27'd0, out_rd}, 32'd30);
    send(5'b00000, 5'd1, 5'd6, 32'hBEEF, 0, 0, 1, 32'h0, 32'h0);
    chk("sub_exc_cnt", {28'd0, ovf_count}, 32'd2);
    send(5'b00010, 5'd1, 5'd0, 32'h1, 1, 0, 0, 32'h0, 32'h40);
    send(5'b00110, 5'd1, 5'd0, 32'h0, 1, 0, 0, 32'h0, 32'h80);
    send(5'b00000, 5'd2, 5'd0, 32'h55, 0, 0, 1, 32'h0, 32'h0);
    send(5'b01000, 5'd0, 5'd5, 32'h100, 0, 0, 1, 32'h0, 32'h0);
    send(5'b11111, 5'd0, 5'd7, 32'h77, 1, 1, 1, 32'h9, 32'h0);
    send(5'b00110, 5'd1, 5'd0, 32'h0, 0, 1, 0, 32'h0, 32'h1234);
    idle(2);

    // Stall: held add, sw offered while the memory stage is blocked
    out_ready = 1'b0;
    send(5'b00000, 5'd0, 5'd9, 32'h99, 0, 0, 0, 32'h0, 32'h0);
    offer(5'b00111, 5'd0, 5'd2, 32'h2000, 0, 0, 0, 32'hCAFEBABE, 32'h0);
    idle(3);
    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    wait_acc();
    chk("sw_mem_we", {31'd0, out_mem_we}, 32'd1);
    idle(2);

    // Flush wins over a simultaneous consume and overflowing capture
    out_ready = 1'b0;
    send(5'b00010, 5'd1, 5'd0, 32'h0, 1, 0, 0, 32'h0, 32'h200);
    out_ready = 1'b1;
    flush = 1'b1;
    offer(5'b00000, 5'd0, 5'd8, 32'h0, 0, 0, 1, 32'h0, 32'h0);
    idle(1);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_cnt", {28'd0, ovf_count}, 32'd2);
    idle(1);

    for (int i = 0; i < 15; i++) send(5'b00101, 5'd0, 5'd1, 32'h0, 0, 0, 1, 32'h0, 32'h0);
    idle(1);
    chk("cnt_sat", {28'd0, ovf_count}, 32'd15);

    // Asynchronous reset in the middle of a stall
    out_ready = 1'b0;
    send(5'b00000, 5'd0, 5'd11, 32'h1111, 0, 0, 0, 32'h5, 32'h0);
    idle(1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_valid", {31'd0, out_valid}, 32'd0);
    chk("async_result", out_result, 32'd0);
    chk("async_rd", {27'd0, out_rd}, 32'd0);
    chk("async_store", out_store_data, 32'd0);
    chk("async_cnt", {28'd0, ovf_count}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    out_ready = 1'b1;
    idle(1);
    send(5'b00000, 5'd0, 5'd12, 32'h42, 0, 0, 0, 32'h0, 32'h0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
